// File: rtl/term_pkg.sv
// Shared definitions for the PageRank termination path: FSM encoding,
// floating-point constants and the NaN helper also used by the term-check stage.
package term_pkg;

    typedef enum logic [7:0] {
        StIdle   = 8'b0000_0001,
        StCount  = 8'b0000_0010,
        StSample = 8'b0000_0100,
        StSub    = 8'b0000_1000,
        StCmp    = 8'b0001_0000,
        StEval   = 8'b0010_0000,
        StDone   = 8'b0100_0000,
        StError  = 8'b1000_0000
    } term_state_e;

    localparam logic [31:0] FP_QNAN        = 32'h7fc0_0000;
    localparam int unsigned ADD_CYCLES_DEF = 8;
    localparam int unsigned CMP_CYCLES_DEF = 2;

    // Exponent all ones with a nonzero mantissa, or the canonical quiet NaN.
    function automatic logic fp_is_nan(input logic [31:0] x);
        return ((x[30:23] == 8'hff) && (x[22:0] != 23'd0)) || (x == FP_QNAN);
    endfunction

endpackage

// File: rtl/float_add_sub.sv
// Single-precision adder with one registered output stage and clock enable.
// Round-to-nearest-even; denormal operands and results are flushed to zero.
module float_add_sub
    import term_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_clk_en,
    input  logic [31:0] i_dataa,
    input  logic [31:0] i_datab,
    output logic [31:0] o_result
);

    logic [31:0]       r_result;
    logic [31:0]       w_big;
    logic [31:0]       w_small;
    logic [31:0]       w_result;
    logic [26:0]       w_ma;
    logic [26:0]       w_ms0;
    logic [26:0]       w_ms;
    logic [26:0]       w_mant;
    logic [27:0]       w_sum;
    logic [7:0]        w_shamt;
    logic [4:0]        w_lz;
    logic              w_found;
    logic [24:0]       w_round;
    logic signed [9:0] w_exp;

    // Align the smaller operand (with sticky), add/subtract, normalise, round.
    always_comb begin
        w_ms    = 27'd0;
        w_mant  = 27'd0;
        w_lz    = 5'd0;
        w_found = 1'b0;
        if (i_dataa[30:0] >= i_datab[30:0]) begin
            w_big   = i_dataa;
            w_small = i_datab;
        end else begin
            w_big   = i_datab;
            w_small = i_dataa;
        end
        // Significand occupies [26:3]; [2:0] are guard, round and sticky.
        w_ma    = (w_big[30:23] == 8'd0) ? 27'd0 : {1'b1, w_big[22:0], 3'b000};
        w_ms0   = (w_small[30:23] == 8'd0) ? 27'd0 : {1'b1, w_small[22:0], 3'b000};
        w_shamt = w_big[30:23] - w_small[30:23];
        if (w_shamt >= 8'd27) begin
            w_ms = {26'd0, |w_ms0};
        end else begin
            w_ms = (w_ms0 >> w_shamt) |
                   {26'd0, |(w_ms0 & ((27'd1 << w_shamt) - 27'd1))};
        end
        w_sum = (w_big[31] == w_small[31]) ? ({1'b0, w_ma} + {1'b0, w_ms})
                                           : ({1'b0, w_ma} - {1'b0, w_ms});
        w_exp = $signed({2'b00, w_big[30:23]});
        if (w_sum[27]) begin
            w_mant = {w_sum[27:2], w_sum[1] | w_sum[0]};
            w_exp  = w_exp + 10'sd1;
        end else begin
            for (int i = 26; i >= 0; i--) begin
                if (!w_found && w_sum[i]) begin
                    w_lz    = 5'(26 - i);
                    w_found = 1'b1;
                end
            end
            w_mant = w_sum[26:0] << w_lz;
            w_exp  = w_exp - $signed({5'b00000, w_lz});
        end
        w_round = {1'b0, w_mant[26:3]} +
                  {24'd0, w_mant[2] & (w_mant[3] | w_mant[1] | w_mant[0])};
        if (w_round[24]) begin
            w_exp = w_exp + 10'sd1;
        end
        // Inf/NaN always sort as the larger magnitude, so only w_big needs a look.
        if (w_big[30:23] == 8'hff) begin
            if ((w_big[22:0] != 23'd0) ||
                ((w_small[30:0] == w_big[30:0]) && (w_small[31] != w_big[31]))) begin
                w_result = FP_QNAN;
            end else begin
                w_result = w_big;
            end
        end else if (w_sum == 28'd0) begin
            w_result = 32'd0;
        end else if (w_exp >= 10'sd255) begin
            w_result = {w_big[31], 8'hff, 23'd0};
        end else if (w_exp <= 10'sd0) begin
            w_result = {w_big[31], 31'd0};
        end else begin
            w_result = {w_big[31], w_exp[7:0], w_round[24] ? w_round[23:1] : w_round[22:0]};
        end
    end

    // Output pipeline stage; holds while the enable is low.
    always_ff @(posedge i_clk) begin
        if (i_clk_en) begin
            r_result <= w_result;
        end
    end

    assign o_result = r_result;

endmodule

// File: rtl/float_cmp.sv
// Single-precision comparator, one registered stage: o_ageb = (dataa >= datab).
// Unordered (NaN) operands compare false.
module float_cmp
    import term_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_clk_en,
    input  logic [31:0] i_dataa,
    input  logic [31:0] i_datab,
    output logic        o_ageb
);

    logic r_ageb;
    logic w_ageb;

    // Map sign-magnitude onto an unsigned ordering key; +0 and -0 share one key.
    function automatic logic [31:0] fp_key(input logic [31:0] x);
        if (x[30:0] == 31'd0) begin
            return 32'h8000_0000;
        end
        return x[31] ? ~x : {1'b1, x[30:0]};
    endfunction

    // Ordered compare of the two operands.
    always_comb begin
        w_ageb = !fp_is_nan(i_dataa) && !fp_is_nan(i_datab) &&
                 (fp_key(i_dataa) >= fp_key(i_datab));
    end

    // Result register; holds while the enable is low.
    always_ff @(posedge i_clk) begin
        if (i_clk_en) begin
            r_ageb <= w_ageb;
        end
    end

    assign o_ageb = r_ageb;

endmodule

// File: rtl/fp_absdiff_cmp.sv
// |cur - prev| <= threshold, built from the shared adder and comparator cores.
// One-hot timers give each core a fixed wait window; both cores have one cycle
// of latency, so ADD_CYCLES and CMP_CYCLES must each be at least 2.
module fp_absdiff_cmp
    import term_pkg::*;
#(
    parameter int unsigned ADD_CYCLES = ADD_CYCLES_DEF,
    parameter int unsigned CMP_CYCLES = CMP_CYCLES_DEF
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_go,
    input  logic [31:0] i_cur,
    input  logic [31:0] i_prev,
    input  logic [31:0] i_threshold,
    output logic        o_add_done,
    output logic        o_done,
    output logic        o_le,
    output logic [31:0] o_absdiff
);

    logic [ADD_CYCLES-1:0] r_add_tmr;
    logic [CMP_CYCLES-1:0] r_cmp_tmr;
    logic [31:0]           r_absdiff;
    logic [31:0]           w_sum;
    logic                  w_unused_sign;

    assign o_add_done    = r_add_tmr[ADD_CYCLES-1];
    assign o_done        = r_cmp_tmr[CMP_CYCLES-1];
    assign o_absdiff     = r_absdiff;
    assign w_unused_sign = w_sum[31];

    // Subtraction is an add with prev's sign flipped.
    float_add_sub u_add (
        .i_clk    (i_clk),
        .i_clk_en (|r_add_tmr),
        .i_dataa  (i_cur),
        .i_datab  ({~i_prev[31], i_prev[30:0]}),
        .o_result (w_sum)
    );

    float_cmp u_cmp (
        .i_clk    (i_clk),
        .i_clk_en (|r_cmp_tmr),
        .i_dataa  (i_threshold),
        .i_datab  (r_absdiff),
        .o_ageb   (o_le)
    );

    // Walk the add window then the compare window; latch |sum| between them.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_add_tmr <= '0;
            r_cmp_tmr <= '0;
            r_absdiff <= 32'd0;
        end else begin
            r_add_tmr <= i_go ? ADD_CYCLES'(1) : (r_add_tmr << 1);
            r_cmp_tmr <= o_add_done ? CMP_CYCLES'(1) : (r_cmp_tmr << 1);
            if (o_add_done) begin
                r_absdiff <= {1'b0, w_sum[30:0]};
            end
        end
    end

endmodule

// File: rtl/term_detect_pr.sv
// Convergence detector: samples accum_value every check_interval cycles and
// asserts terminate once |change| <= threshold for stable_target checks in a row.
module term_detect_pr
    import term_pkg::*;
#(
    parameter int unsigned ADD_CYCLES = ADD_CYCLES_DEF,
    parameter int unsigned CMP_CYCLES = CMP_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] accum_value,
    input  logic [31:0] check_interval,
    input  logic [31:0] threshold,
    input  logic [7:0]  stable_target,
    output logic        terminate,
    output logic        nan_error,
    output logic        busy,
    output logic [31:0] checks_done
);

    term_state_e r_state, w_state_nxt;
    logic [31:0] r_prev, w_prev_nxt;
    logic [31:0] r_cur, w_cur_nxt;
    logic [31:0] r_timer, w_timer_nxt;
    logic [7:0]  r_stable, w_stable_nxt;
    logic [31:0] r_checks, w_checks_nxt;
    logic        r_terminate, w_terminate_nxt;
    logic        r_nan_error, w_nan_error_nxt;
    logic        r_busy, w_busy_nxt;
    logic        w_go;
    logic        w_add_done;
    logic        w_done;
    logic        w_le;
    logic [31:0] w_absdiff;
    logic [31:0] w_interval;
    logic [7:0]  w_target;
    logic [7:0]  w_stable_inc;

    assign terminate   = r_terminate;
    assign nan_error   = r_nan_error;
    assign busy        = r_busy;
    assign checks_done = r_checks;

    assign w_interval   = (check_interval == 32'd0) ? 32'd1 : check_interval;
    assign w_target     = (stable_target == 8'd0) ? 8'd1 : stable_target;
    assign w_stable_inc = !w_le ? 8'd0 : ((r_stable == 8'hff) ? 8'hff : r_stable + 8'd1);

    fp_absdiff_cmp #(
        .ADD_CYCLES (ADD_CYCLES),
        .CMP_CYCLES (CMP_CYCLES)
    ) u_absdiff_cmp (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_go        (w_go),
        .i_cur       (r_cur),
        .i_prev      (r_prev),
        .i_threshold (threshold),
        .o_add_done  (w_add_done),
        .o_done      (w_done),
        .o_le        (w_le),
        .o_absdiff   (w_absdiff)
    );

    // Next-state and registered-output logic.
    always_comb begin
        w_state_nxt     = r_state;
        w_prev_nxt      = r_prev;
        w_cur_nxt       = r_cur;
        w_timer_nxt     = r_timer;
        w_stable_nxt    = r_stable;
        w_checks_nxt    = r_checks;
        w_terminate_nxt = r_terminate;
        w_nan_error_nxt = r_nan_error;
        w_busy_nxt      = r_busy;
        w_go            = 1'b0;
        unique case (r_state)
            StIdle, StDone, StError: begin
                if (start) begin
                    w_prev_nxt      = accum_value;
                    w_stable_nxt    = 8'd0;
                    w_checks_nxt    = 32'd0;
                    w_terminate_nxt = 1'b0;
                    w_nan_error_nxt = 1'b0;
                    w_busy_nxt      = 1'b1;
                    w_timer_nxt     = w_interval;
                    w_state_nxt     = StCount;
                end
            end
            StCount: begin
                w_timer_nxt = r_timer - 32'd1;
                if (r_timer <= 32'd1) begin
                    w_state_nxt = StSample;
                end
            end
            StSample: begin
                w_cur_nxt = accum_value;
                if (fp_is_nan(accum_value)) begin
                    w_nan_error_nxt = 1'b1;
                    w_busy_nxt      = 1'b0;
                    w_state_nxt     = StError;
                end else begin
                    w_go        = 1'b1;
                    w_state_nxt = StSub;
                end
            end
            StSub: begin
                if (w_add_done) begin
                    w_state_nxt = StCmp;
                end
            end
            StCmp: begin
                if (w_done) begin
                    w_state_nxt = StEval;
                end
            end
            StEval: begin
                w_checks_nxt = (r_checks == 32'hffff_ffff) ? r_checks : r_checks + 32'd1;
                w_prev_nxt   = r_cur;
                w_stable_nxt = w_stable_inc;
                if (w_stable_inc >= w_target) begin
                    w_terminate_nxt = 1'b1;
                    w_busy_nxt      = 1'b0;
                    w_state_nxt     = StDone;
                end else begin
                    w_timer_nxt = w_interval;
                    w_state_nxt = StCount;
                end
            end
            default: begin
                w_state_nxt = StIdle;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= StIdle;
            r_prev      <= 32'd0;
            r_cur       <= 32'd0;
            r_timer     <= 32'd0;
            r_stable    <= 8'd0;
            r_checks    <= 32'd0;
            r_terminate <= 1'b0;
            r_nan_error <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_prev      <= w_prev_nxt;
            r_cur       <= w_cur_nxt;
            r_timer     <= w_timer_nxt;
            r_stable    <= w_stable_nxt;
            r_checks    <= w_checks_nxt;
            r_terminate <= w_terminate_nxt;
            r_nan_error <= w_nan_error_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

endmodule

// File: tb/tb_term_detect_pr.sv
// Directed bench for term_detect_pr: a table of single-scenario vectors plus
// hand-written sequences for the multi-cycle corner cases.
module tb_term_detect_pr;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] accum_value;
    logic [31:0] check_interval;
    logic [31:0] threshold;
    logic [7:0]  stable_target;
    logic        terminate;
    logic        nan_error;
    logic        busy;
    logic [31:0] checks_done;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    term_detect_pr #(
        .ADD_CYCLES (8),
        .CMP_CYCLES (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .accum_value    (accum_value),
        .check_interval (check_interval),
        .threshold      (threshold),
        .stable_target  (stable_target),
        .terminate      (terminate),
        .nan_error      (nan_error),
        .busy           (busy),
        .checks_done    (checks_done)
    );

    typedef struct {
        logic [31:0] a0;      // accum_value when start is sampled
        logic [31:0] a1;      // accum_value afterwards
        logic [31:0] ivl;
        logic [31:0] thr;
        logic [7:0]  tgt;
        int          cyc;     // cycles after the start edge before checking
        logic        term;
        logic        nan;
        logic        bsy;
        logic [31:0] checks;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic t, input logic n, input logic b,
                              input logic [31:0] c);
        check({name, ".terminate"}, {31'd0, terminate}, {31'd0, t});
        check({name, ".nan_error"}, {31'd0, nan_error}, {31'd0, n});
        check({name, ".busy"}, {31'd0, busy}, {31'd0, b});
        check({name, ".checks_done"}, checks_done, c);
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        wait_n(1);
        reset = 1'b0;
    endtask

    // Returns just after the edge that samples start.
    task automatic pulse_start();
        start = 1'b1;
        wait_n(1);
        start = 1'b0;
    endtask

    task automatic setup(input logic [31:0] ivl, input logic [31:0] thr, input logic [7:0] tgt);
        check_interval = ivl;
        threshold      = thr;
        stable_target  = tgt;
    endtask

    initial begin
        // a0, a1, interval, threshold, target, cycles, term, nan, busy, checks
        tbl[0] = '{32'h3f800000, 32'h3fc00000, 32'd4, 32'h3c23d70a, 8'd3, 64, 1'b1, 1'b0, 1'b0, 32'd4};
        tbl[1] = '{32'h3f800000, 32'h3f800000, 32'd0, 32'h3c23d70a, 8'd0, 13, 1'b1, 1'b0, 1'b0, 32'd1};
        tbl[2] = '{32'h3f800000, 32'h7fc00000, 32'd4, 32'h3c23d70a, 8'd3, 5,  1'b0, 1'b1, 1'b0, 32'd0};
        tbl[3] = '{32'h3f800000, 32'h3fc00000, 32'd2, 32'h3f000000, 8'd1, 14, 1'b1, 1'b0, 1'b0, 32'd1};
        tbl[4] = '{32'h3f800000, 32'h3fc00000, 32'd2, 32'h3effffff, 8'd1, 14, 1'b0, 1'b0, 1'b1, 32'd1};
        tbl[5] = '{32'h00000000, 32'h80000000, 32'd1, 32'h00000000, 8'd1, 13, 1'b1, 1'b0, 1'b0, 32'd1};
        tbl[6] = '{32'h42c80000, 32'h42c88000, 32'd3, 32'h3e800000, 8'd1, 15, 1'b1, 1'b0, 1'b0, 32'd1};
        tbl[7] = '{32'h40000000, 32'h3f800000, 32'd1, 32'h3f000000, 8'd1, 13, 1'b0, 1'b0, 1'b1, 32'd1};

        reset          = 1'b1;
        start          = 1'b0;
        accum_value    = 32'd0;
        check_interval = 32'd0;
        threshold      = 32'd0;
        stable_target  = 8'd0;
        wait_n(2);
        reset = 1'b0;
        check_outs("reset", 1'b0, 1'b0, 1'b0, 32'd0);

        for (int i = 0; i < 8; i++) begin
            do_reset();
            setup(tbl[i].ivl, tbl[i].thr, tbl[i].tgt);
            accum_value = tbl[i].a0;
            pulse_start();
            accum_value = tbl[i].a1;
            wait_n(tbl[i].cyc);
            check_outs($sformatf("vec%0d", i), tbl[i].term, tbl[i].nan, tbl[i].bsy,
                       tbl[i].checks);
        end

        // Convergence edge timing: terminate rises exactly on the edge leaving check 4.
        do_reset();
        setup(32'd4, 32'h3c23d70a, 8'd3);
        accum_value = 32'h3f800000;
        pulse_start();
        check("conv.busy_rise", {31'd0, busy}, 32'd1);
        accum_value = 32'h3fc00000;
        wait_n(16);
        check("conv.checks_after1", checks_done, 32'd1);
        wait_n(47);
        check_outs("conv.edge63", 1'b0, 1'b0, 1'b1, 32'd3);
        wait_n(1);
        check_outs("conv.edge64", 1'b1, 1'b0, 1'b0, 32'd4);

        // Oscillation between 1.0 and 2.0 never becomes stable.
        do_reset();
        setup(32'd4, 32'h3f000000, 8'd2);
        accum_value = 32'h3f800000;
        pulse_start();
        accum_value = 32'h40000000;
        for (int k = 0; k < 20; k++) begin
            wait_n(16);
            accum_value = (accum_value == 32'h40000000) ? 32'h3f800000 : 32'h40000000;
        end
        check_outs("osc", 1'b0, 1'b0, 1'b1, 32'd20);

        // Signalling NaN pattern errors out; a new start clears the flags.
        do_reset();
        setup(32'd4, 32'h3c23d70a, 8'd1);
        accum_value = 32'h3f800000;
        pulse_start();
        accum_value = 32'h7f800001;
        wait_n(5);
        check_outs("snan", 1'b0, 1'b1, 1'b0, 32'd0);
        wait_n(3);
        check("snan.held", {31'd0, nan_error}, 32'd1);
        accum_value = 32'h3f800000;
        pulse_start();
        check_outs("snan.restart", 1'b0, 1'b0, 1'b1, 32'd0);
        wait_n(16);
        check_outs("snan.recover", 1'b1, 1'b0, 1'b0, 32'd1);

        // Start during SUB is ignored: timing is unchanged.
        do_reset();
        setup(32'd4, 32'h3c23d70a, 8'd2);
        accum_value = 32'h3f800000;
        pulse_start();
        wait_n(6);
        start = 1'b1;
        wait_n(1);
        start = 1'b0;
        wait_n(9);
        check_outs("busy_start.e16", 1'b0, 1'b0, 1'b1, 32'd1);
        wait_n(15);
        check("busy_start.e31", {31'd0, terminate}, 32'd0);
        wait_n(1);
        check_outs("busy_start.e32", 1'b1, 1'b0, 1'b0, 32'd2);

        // Reset during CMP of the second check, then a clean rerun.
        do_reset();
        setup(32'd4, 32'h3c23d70a, 8'd3);
        accum_value = 32'h3f800000;
        pulse_start();
        accum_value = 32'h3fc00000;
        wait_n(29);
        check("rst_cmp.before", checks_done, 32'd1);
        reset = 1'b1;
        wait_n(1);
        reset = 1'b0;
        check_outs("rst_cmp.after", 1'b0, 1'b0, 1'b0, 32'd0);
        accum_value = 32'h3f800000;
        pulse_start();
        accum_value = 32'h3fc00000;
        wait_n(63);
        check_outs("rst_cmp.e63", 1'b0, 1'b0, 1'b1, 32'd3);
        wait_n(1);
        check_outs("rst_cmp.e64", 1'b1, 1'b0, 1'b0, 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
